// File: rtl/cpu_mon_pkg.sv
// Shared definitions for the CPU run monitor: FSM state encoding and the
// signature fold step (rotate-left-by-one, then XOR in data and register address).
package cpu_mon_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int unsigned SIG_MAX_W = 64;

  // Operands are zero-extended to SIG_MAX_W; the rotation wraps at bit width-1.
  function automatic logic [SIG_MAX_W-1:0] sig_step(
    input logic [SIG_MAX_W-1:0] sig,
    input logic [SIG_MAX_W-1:0] data,
    input logic [SIG_MAX_W-1:0] addr,
    input int unsigned          width
  );
    logic [SIG_MAX_W-1:0] mask;
    logic [SIG_MAX_W-1:0] rot;
    mask = (width >= SIG_MAX_W) ? '1 : ((SIG_MAX_W'(1) << width) - SIG_MAX_W'(1));
    rot  = ((sig << 1) | (sig >> (width - 1))) & mask;
    return (rot ^ data ^ addr) & mask;
  endfunction

endpackage

// File: rtl/cpu_mon_sig.sv
// Signature accumulator and writeback counter; folds writebacks only while enabled.
module cpu_mon_sig
  import cpu_mon_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                REG_AW   = 4,
  parameter int                CNT_W    = 32,
  parameter logic [DATA_W-1:0] SIG_SEED = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] sig_o,
  output logic [DATA_W-1:0] sig_next_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0]  count_q, count_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    sig_d   = sig_q;
    count_d = count_q;
    if (en_i && wb_en_i) begin
      sig_d   = DATA_W'(sig_step(SIG_MAX_W'(sig_q), SIG_MAX_W'(wb_data_i),
                                 SIG_MAX_W'(wb_addr_i), DATA_W));
      count_d = sat_inc(count_q);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sig_q   <= SIG_SEED;
      count_q <= '0;
    end else begin
      sig_q   <= sig_d;
      count_q <= count_d;
    end
  end

  assign sig_o      = sig_q;
  assign sig_next_o = sig_d;
  assign count_o    = count_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller beside the CPU: sequences CPU reset release, counts RUN cycles,
// detects branch-to-self halt or watchdog timeout and reports pass/fail.
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int                PC_W         = 32,
  parameter int                DATA_W       = 32,
  parameter int                REG_AW       = 4,
  parameter int                CNT_W        = 32,
  parameter int                RESET_CYCLES = 4,
  parameter int                HALT_REPEAT  = 8,
  parameter int                MAX_CYCLES   = 100000,
  parameter logic [DATA_W-1:0] SIG_SEED     = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  output logic              cpu_rst_out,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              wb_en_in,
  input  logic [REG_AW-1:0] wb_addr_in,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic [DATA_W-1:0] expected_sig_in,
  output logic [CNT_W-1:0]  cycle_count_out,
  output logic [CNT_W-1:0]  wb_count_out,
  output logic [DATA_W-1:0] signature_out,
  output logic              done_out,
  output logic              pass_out,
  output logic              timeout_out
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int REP_W  = $clog2(HALT_REPEAT + 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [PC_W-1:0]   pc_prev_q, pc_prev_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              to_q, to_d;

  logic              run;
  logic              pc_same;
  logic              halt_hit;
  logic              wd_hit;
  logic [DATA_W-1:0] sig_next;

  assign run      = (state_q == ST_RUN);
  assign pc_same  = (pc_in == pc_prev_q);
  assign halt_hit = run && pc_same && ((rep_q + REP_W'(1)) == REP_W'(HALT_REPEAT));
  assign wd_hit   = run && ((cyc_q + CNT_W'(1)) == CNT_W'(MAX_CYCLES));

  cpu_mon_sig #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .CNT_W    (CNT_W),
    .SIG_SEED (SIG_SEED)
  ) u_sig (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en_i       (run),
    .wb_en_i    (wb_en_in),
    .wb_addr_i  (wb_addr_in),
    .wb_data_i  (wb_data_in),
    .sig_o      (signature_out),
    .sig_next_o (sig_next),
    .count_o    (wb_count_out)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_HOLD;
      hold_q    <= '0;
      cyc_q     <= '0;
      rep_q     <= '0;
      pc_prev_q <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cyc_q     <= cyc_d;
      rep_q     <= rep_d;
      pc_prev_q <= pc_prev_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      to_q      <= to_d;
    end
  end

  // Halt is checked first so a halt landing on the watchdog cycle wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: if (hold_q == HOLD_W'(RESET_CYCLES - 1)) state_d = ST_RUN;
      ST_RUN: begin
        if (halt_hit)    state_d = ST_HALTED;
        else if (wd_hit) state_d = ST_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    hold_d    = hold_q;
    cyc_d     = cyc_q;
    rep_d     = rep_q;
    pc_prev_d = pc_prev_q;
    done_d    = done_q;
    pass_d    = pass_q;
    to_d      = to_q;
    cpu_rst_d = (state_d == ST_HOLD);
    if (state_q == ST_HOLD) hold_d = hold_q + HOLD_W'(1);
    if (run) begin
      cyc_d     = cyc_q + CNT_W'(1);
      pc_prev_d = pc_in;
      rep_d     = pc_same ? rep_q + REP_W'(1) : '0;
      // The halt-cycle writeback is part of the signature being judged.
      if (halt_hit) begin
        done_d = 1'b1;
        pass_d = (sig_next == expected_sig_in);
      end else if (wd_hit) begin
        done_d = 1'b1;
        to_d   = 1'b1;
      end
    end
  end

  assign cpu_rst_out     = cpu_rst_q;
  assign cycle_count_out = cyc_q;
  assign done_out        = done_q;
  assign pass_out        = pass_q;
  assign timeout_out     = to_q;

endmodule
